// File: rtl/chad_mcu_pkg.sv
// Shared constants and the boot sequencer state type for the chad_mcu shell.
package chad_mcu_pkg;

    localparam logic [7:0]  CMD_READ  = 8'h03;
    localparam logic [23:0] BOOT_ADDR = 24'h000000;

    typedef enum logic [2:0] {
        WAIT,
        CMD,
        DATA,
        SEND,
        RUN
    } state_t;

endpackage

// File: rtl/chad_mcu_uart.sv
// 8N1 UART: transmit shifter fed by one holding register, and a receive sampler.
// Handshake: a tx byte transfers on a clk edge where tx_valid and tx_ready are both high;
// rx_valid is a one-clk strobe with rx_data stable for that clk and has no back-pressure.
module chad_mcu_uart
    import chad_mcu_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rxd,
    output logic       txd
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    logic [7:0]  hold;
    logic        hold_full;
    logic [9:0]  tx_sh;
    logic        tx_busy;
    logic [15:0] tx_cnt;
    logic [3:0]  tx_bit;

    assign tx_ready = !hold_full;
    assign txd      = tx_busy ? tx_sh[0] : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= 8'h00;
            hold_full <= 1'b0;
            tx_sh     <= 10'h3ff;
            tx_busy   <= 1'b0;
            tx_cnt    <= 16'd0;
            tx_bit    <= 4'd0;
        end else begin
            if (tx_valid && !hold_full) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end
            if (!tx_busy) begin
                if (hold_full) begin
                    tx_sh     <= {1'b1, hold, 1'b0};
                    tx_busy   <= 1'b1;
                    tx_cnt    <= 16'd0;
                    tx_bit    <= 4'd0;
                    hold_full <= 1'b0;
                end
            end else if (tx_cnt == BAUD_LAST) begin
                tx_cnt <= 16'd0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx_sh  <= {1'b1, tx_sh[9:1]};
                    tx_bit <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_active;
    logic [3:0]  rx_idx;
    logic [15:0] rx_cnt;
    logic [7:0]  rx_sh;

    // rx_idx 0 is the start-bit re-check at half a bit; 1..8 data; 9 stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_active <= 1'b0;
            rx_idx    <= 4'd0;
            rx_cnt    <= 16'd0;
            rx_sh     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            if (!rx_active) begin
                if (rx_prev && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= 16'd0;
                    rx_idx    <= 4'd0;
                end
            end else if (rx_idx == 4'd0) begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt <= 16'd0;
                    if (rx_s2) begin
                        rx_active <= 1'b0;
                    end else begin
                        rx_idx <= 4'd1;
                    end
                end else begin
                    rx_cnt <= rx_cnt + 16'd1;
                end
            end else if (rx_cnt == BAUD_LAST) begin
                rx_cnt <= 16'd0;
                if (rx_idx == 4'd9) begin
                    rx_active <= 1'b0;
                    if (rx_s2) begin
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                    end
                end else begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_idx <= rx_idx + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/chad_mcu.sv
// MCU shell top: boots by reading BOOT_BYTES from SPI NOR flash with READ 0x03,
// sends the 8-bit checksum on the UART, then echoes received bytes.
module chad_mcu
    import chad_mcu_pkg::*;
#(
    parameter int unsigned BOOT_DELAY = 30000,
    parameter int unsigned BOOT_BYTES = 16,
    parameter int unsigned SCK_DIV    = 2,
    parameter int unsigned BAUD_DIV   = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       txd,
    output logic       sclk,
    output logic       cs_n,
    input  logic [3:0] qdi,
    output logic [3:0] qdo,
    output logic [3:0] oe,
    output state_t     state,
    output logic [7:0] checksum
);

    localparam logic [31:0] WAIT_LAST = 32'(BOOT_DELAY - 1);
    localparam logic [31:0] BIT_TOTAL = 32'(32 + 8 * BOOT_BYTES);
    localparam logic [15:0] SCK_LAST  = 16'(SCK_DIV - 1);

    state_t      next_state;
    logic [31:0] wait_cnt;
    logic [31:0] bit_cnt;
    logic [15:0] div_cnt;
    logic        sclk_q;
    logic [31:0] mosi_sh;
    logic [7:0]  rx_byte;
    logic        boot_done;
    logic        spi_active;
    logic        sck_edge;

    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        unused_pads;

    assign unused_pads = ^{qdi[3:2], qdi[0]};

    // bit_cnt counts completed sclk pulses (falling edges).
    assign boot_done  = (bit_cnt == BIT_TOTAL);
    assign spi_active = ((state == CMD) || (state == DATA)) && !boot_done;
    assign sck_edge   = spi_active && (div_cnt == SCK_LAST);
    assign sclk       = sclk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cs_n       = 1'b1;
        oe         = 4'b0000;
        qdo        = 4'b0000;
        tx_valid   = 1'b0;
        tx_data    = rx_data;
        unique case (state)
            WAIT: begin
                if (wait_cnt == WAIT_LAST) next_state = CMD;
            end
            CMD: begin
                cs_n = 1'b0;
                oe   = 4'b0001;
                qdo  = {3'b000, mosi_sh[31]};
                if (sck_edge && sclk_q && (bit_cnt == 32'd31)) next_state = DATA;
            end
            DATA: begin
                // The cycle after the last falling sclk edge still holds cs_n low.
                cs_n = 1'b0;
                if (boot_done) next_state = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = checksum;
                if (tx_ready) next_state = RUN;
            end
            RUN: begin
                tx_valid = rx_valid;
            end
            default: next_state = WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 32'd0;
            bit_cnt  <= 32'd0;
            div_cnt  <= 16'd0;
            sclk_q   <= 1'b0;
            mosi_sh  <= {CMD_READ, BOOT_ADDR};
            rx_byte  <= 8'h00;
            checksum <= 8'h00;
        end else begin
            if (state == WAIT) wait_cnt <= wait_cnt + 32'd1;
            if (!spi_active) begin
                div_cnt <= 16'd0;
            end else if (sck_edge) begin
                div_cnt <= 16'd0;
                sclk_q  <= !sclk_q;
                if (!sclk_q) begin
                    if (state == DATA) begin
                        rx_byte <= {rx_byte[6:0], qdi[1]};
                        if (bit_cnt[2:0] == 3'd7) checksum <= checksum + {rx_byte[6:0], qdi[1]};
                    end
                end else begin
                    bit_cnt <= bit_cnt + 32'd1;
                    mosi_sh <= {mosi_sh[30:0], 1'b0};
                end
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

    chad_mcu_uart #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rxd     (rxd),
        .txd     (txd)
    );

endmodule

// File: tb/tb_chad_mcu.sv
// Bench for chad_mcu: flash image model, UART line driver/decoder, checksum reference.
module tb_chad_mcu;
  import chad_mcu_pkg::*;

  localparam int BD   = 100;
  localparam int BAUD = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rxd = 1'b1;
  logic       rxd1 = 1'b1;
  logic       txd0, txd1, sclk0, sclk1, cs_n0, cs_n1;
  logic [3:0] qdi0, qdi1, qdo0, qdo1, oe0, oe1;
  state_t     st0, st1;
  logic [7:0] csum0, csum1;

  chad_mcu #(.BOOT_DELAY(BD), .BOOT_BYTES(16), .SCK_DIV(2), .BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd0), .sclk(sclk0), .cs_n(cs_n0),
    .qdi(qdi0), .qdo(qdo0), .oe(oe0), .state(st0), .checksum(csum0)
  );

  chad_mcu #(.BOOT_DELAY(BD), .BOOT_BYTES(1), .SCK_DIV(1), .BAUD_DIV(BAUD)) dut1 (
    .clk(clk), .rst(rst), .rxd(rxd1), .txd(txd1), .sclk(sclk1), .cs_n(cs_n1),
    .qdi(qdi1), .qdo(qdo1), .oe(oe1), .state(st1), .checksum(csum1)
  );

  // flash image: 0x00..0x0F at 0..15, filler above
  logic [7:0] image [256];
  initial for (int a = 0; a < 256; a++) image[a] = (a < 16) ? 8'(a) : 8'hA5;

  function automatic logic flash_bit(input logic [31:0] cmd, input int d);
    int a;
    logic [7:0] b;
    a = (int'(cmd[23:0]) + d / 8) & 255;
    b = image[a];
    return b[7 - (d % 8)];
  endfunction

  function automatic logic [7:0] model_checksum(input int n);
    int s;
    s = 0;
    for (int a = 0; a < n; a++) s += int'(image[a]);
    return 8'(s);
  endfunction

  // flash models; pads with pull-ups resolve to 1 when nobody drives them
  int fl_bits0, fl_frame0, bad0, fl_bits1, fl_frame1, bad1;
  logic [31:0] fl_cmd0, fl_cmd1;
  logic fl_so0, fl_so1;

  assign qdi0 = {2'b11, (!cs_n0 && fl_bits0 >= 32) ? fl_so0 : 1'b1, oe0[0] ? qdo0[0] : 1'b1};
  assign qdi1 = {2'b11, (!cs_n1 && fl_bits1 >= 32) ? fl_so1 : 1'b1, oe1[0] ? qdo1[0] : 1'b1};

  always @(posedge sclk0 or posedge cs_n0) begin
    if (cs_n0) begin
      if (fl_bits0 != 0) fl_frame0 = fl_bits0;
      fl_bits0 = 0;
    end else begin
      if (fl_bits0 < 32) fl_cmd0 = {fl_cmd0[30:0], qdi0[0]};
      fl_bits0++;
    end
  end
  always @(negedge sclk0) if (!cs_n0 && fl_bits0 >= 32) fl_so0 = flash_bit(fl_cmd0, fl_bits0 - 32);
  always @(posedge sclk0) if (cs_n0) bad0++;

  always @(posedge sclk1 or posedge cs_n1) begin
    if (cs_n1) begin
      if (fl_bits1 != 0) fl_frame1 = fl_bits1;
      fl_bits1 = 0;
    end else begin
      if (fl_bits1 < 32) fl_cmd1 = {fl_cmd1[30:0], qdi1[0]};
      fl_bits1++;
    end
  end
  always @(negedge sclk1) if (!cs_n1 && fl_bits1 >= 32) fl_so1 = flash_bit(fl_cmd1, fl_bits1 - 32);
  always @(posedge sclk1) if (cs_n1) bad1++;

  // txd decoders: sample at bit centres measured from the first low sample
  logic [7:0] got_q0[$], got_q1[$];
  logic [1:0] txd_v;
  int         mon_cnt [2];
  logic [7:0] mon_sh [2];
  logic       mon_busy [2];
  int         frame_bad [2];
  assign txd_v = {txd1, txd0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mon_busy[i] = 1'b0;
      end else if (!mon_busy[i]) begin
        if (!txd_v[i]) begin
          mon_busy[i] = 1'b1;
          mon_cnt[i]  = 0;
        end
      end else begin
        mon_cnt[i]++;
        if (mon_cnt[i] % BAUD == BAUD / 2) begin
          if (mon_cnt[i] / BAUD == 0) begin
            if (txd_v[i]) mon_busy[i] = 1'b0;
          end else if (mon_cnt[i] / BAUD <= 8) begin
            mon_sh[i] = {txd_v[i], mon_sh[i][7:1]};
          end else begin
            mon_busy[i] = 1'b0;
            if (!txd_v[i]) frame_bad[i]++;
            else if (i == 0) got_q0.push_back(mon_sh[i]);
            else got_q1.push_back(mon_sh[i]);
          end
        end
      end
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int n, base, rd0;
  logic [7:0] b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: 8N1 frame on rxd with a chosen stop bit, then one idle bit
  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (BAUD) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd0, 1'b1);
    check("rst_sclk", sclk0, 1'b0);
    check("rst_cs_n", cs_n0, 1'b1);
    check("rst_qdo", qdo0, 4'b0000);
    check("rst_oe", oe0, 4'b0000);
    check("rst_state", 32'(st0), 32'(WAIT));
    check("rst_checksum", csum0, 8'h00);

    // boot, with a byte arriving on rxd during WAIT that must never be echoed
    @(negedge clk);
    rst = 1'b0;
    fork
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      begin
        n = 0;
        while (cs_n0 && n < 1000) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("cs_fall_delay", n, BD);
        check("oe_cmd", oe0, 4'b0001);
      end
    join

    n = 0;
    while (!cs_n0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("boot_end_seen", n < 5000, 1'b1);
    check("cmd_bits", fl_cmd0, 32'h03000000);
    check("sclk_pulses", fl_frame0, 160);
    check("oe_after_boot", oe0, 4'b0000);

    n = 0;
    while ((got_q0.size() < 1 || got_q1.size() < 1) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("checksum_tx_seen", n < 3000, 1'b1);
    if (got_q0.size() >= 1) check("checksum_tx", got_q0[0], model_checksum(16));
    check("checksum_reg", csum0, model_checksum(16));
    check("state_run", 32'(st0), 32'(RUN));
    check("small_pulses", fl_frame1, 40);
    check("small_cmd", fl_cmd1, 32'h03000000);
    if (got_q1.size() >= 1) check("small_checksum_tx", got_q1[0], model_checksum(1));
    rd0 = 1;

    // echo: fixed patterns then random bytes; one framing-error byte mid-stream
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < exp_q.size(); i++) send_byte(exp_q[i], 1'b1);
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    send_byte(b, 1'b1);

    n = 0;
    while (got_q0.size() < 1 + exp_q.size() && n < 4000) begin
      @(posedge clk);
      n++;
    end
    repeat (30 * BAUD) @(posedge clk);
    check("echo_count", got_q0.size(), 1 + exp_q.size());
    while (exp_q.size() > 0) begin
      if (rd0 < got_q0.size()) check("echo_byte", got_q0[rd0], exp_q[0]);
      else check("echo_missing", 0, 1);
      void'(exp_q.pop_front());
      rd0++;
    end
    check("frame_err0", frame_bad[0], 0);

    // reboot, then reset again in the middle of data byte 5
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (fl_bits0 < 32 + 8 * 5 + 4 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("byte5_reached", n < 3000, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cs_n", cs_n0, 1'b1);
    check("midrst_oe", oe0, 4'b0000);
    check("midrst_sclk", sclk0, 1'b0);
    check("midrst_qdo", qdo0, 4'b0000);
    check("midrst_txd", txd0, 1'b1);
    check("midrst_state", 32'(st0), 32'(WAIT));
    @(negedge clk);
    rst = 1'b0;
    base = got_q0.size();
    n = 0;
    while (got_q0.size() <= base && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("reboot_tx_seen", n < 5000, 1'b1);
    if (got_q0.size() > base) check("reboot_checksum", got_q0[base], model_checksum(16));
    check("reboot_pulses", fl_frame0, 160);
    check("no_pulse_deselected0", bad0, 0);
    check("no_pulse_deselected1", bad1, 0);
    check("frame_err_all", frame_bad[0] + frame_bad[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
